alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 174 +++++++++++++++++
 tb/tb_alu_mc.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with iterative multiply and restoring divide
module alu_mc #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 2*DATA_WIDTH,
  parameter int FUN_WIDTH    = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  input  logic [FUN_WIDTH-1:0]    ALU_FUN,
  input  logic                    SIGNED_EN,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [RESULT_WIDTH-1:0] ALU_OUT,
  output logic                    OUT_VALID,
  output logic                    ERR
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam logic [FUN_WIDTH-1:0] OP_ADD  = 'd0;
  localparam logic [FUN_WIDTH-1:0] OP_SUB  = 'd1;
  localparam logic [FUN_WIDTH-1:0] OP_MUL  = 'd2;
  localparam logic [FUN_WIDTH-1:0] OP_DIV  = 'd3;
  localparam logic [FUN_WIDTH-1:0] OP_AND  = 'd4;
  localparam logic [FUN_WIDTH-1:0] OP_OR   = 'd5;
  localparam logic [FUN_WIDTH-1:0] OP_NAND = 'd6;
  localparam logic [FUN_WIDTH-1:0] OP_NOR  = 'd7;
  localparam logic [FUN_WIDTH-1:0] OP_XOR  = 'd8;
  localparam logic [FUN_WIDTH-1:0] OP_XNOR = 'd9;
  localparam logic [FUN_WIDTH-1:0] OP_EQ   = 'd10;
  localparam logic [FUN_WIDTH-1:0] OP_GT   = 'd11;
  localparam logic [FUN_WIDTH-1:0] OP_SHR  = 'd12;
  localparam logic [FUN_WIDTH-1:0] OP_SHL  = 'd13;

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic [RESULT_WIDTH-1:0] acc;    // MUL partial product / DIV remainder
  logic [RESULT_WIDTH-1:0] opnd;   // MUL shifted multiplicand / DIV divisor
  logic [N-1:0]            work;   // MUL multiplier / DIV dividend shifting into quotient
  logic                    neg_q;  // negate product or quotient at the end
  logic                    neg_r;  // negate remainder at the end
  logic                    ovf;    // signed most-negative / -1 divide

  logic [RESULT_WIDTH-1:0] a_ext, b_ext, sc_res;
  logic                    sc_err, a_gt_b;
  logic [N-1:0]            a_mag, b_mag, div_q, div_r;
  logic [N:0]              rem_sh, rem_diff;

  assign IN_READY = (state == IDLE);

  assign a_ext  = SIGNED_EN ? {{N{A[N-1]}}, A} : {{N{1'b0}}, A};
  assign b_ext  = SIGNED_EN ? {{N{B[N-1]}}, B} : {{N{1'b0}}, B};
  assign a_gt_b = SIGNED_EN ? ($signed(A) > $signed(B)) : (A > B);

  // Iterative units work on magnitudes; signs are restored at the end.
  assign a_mag = (SIGNED_EN && A[N-1]) ? -A : A;
  assign b_mag = (SIGNED_EN && B[N-1]) ? -B : B;

  // One restoring-division step: shift next dividend bit in, trial-subtract.
  assign rem_sh   = {acc[N-1:0], work[N-1]};
  assign rem_diff = rem_sh - {1'b0, opnd[N-1:0]};

  assign div_q = neg_q ? -work : work;
  assign div_r = neg_r ? -acc[N-1:0] : acc[N-1:0];

  // Single-cycle result and error for the current opcode.
  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    case (ALU_FUN)
      OP_ADD:  sc_res = a_ext + b_ext;
      OP_SUB:  sc_res = a_ext - b_ext;
      OP_MUL, OP_DIV: sc_res = '0;
      OP_AND:  sc_res = {{N{1'b0}}, A & B};
      OP_OR:   sc_res = {{N{1'b0}}, A | B};
      OP_NAND: sc_res = {{N{1'b0}}, ~(A & B)};
      OP_NOR:  sc_res = {{N{1'b0}}, ~(A | B)};
      OP_XOR:  sc_res = {{N{1'b0}}, A ^ B};
      OP_XNOR: sc_res = {{N{1'b0}}, ~(A ^ B)};
      OP_EQ:   sc_res = (A == B) ? RESULT_WIDTH'(3) : '0;
      OP_GT:   sc_res = a_gt_b ? RESULT_WIDTH'(1) : RESULT_WIDTH'(2);
      OP_SHR:  sc_res = {{N{1'b0}}, SIGNED_EN & A[N-1], A[N-1:1]};
      OP_SHL:  sc_res = {{N{1'b0}}, A[N-2:0], 1'b0};
      default: sc_err = 1'b1;
    endcase
  end

  // Accept requests, step the MUL/DIV iterations and register results.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      work      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf       <= 1'b0;
      ALU_OUT   <= '0;
      OUT_VALID <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            cnt <= '0;
            acc <= '0;
            if (ALU_FUN == OP_MUL) begin
              opnd  <= {{N{1'b0}}, a_mag};
              work  <= b_mag;
              neg_q <= SIGNED_EN & (A[N-1] ^ B[N-1]);
              state <= MUL;
            end else if (ALU_FUN == OP_DIV && B != '0) begin
              opnd  <= {{N{1'b0}}, b_mag};
              work  <= a_mag;
              neg_q <= SIGNED_EN & (A[N-1] ^ B[N-1]);
              neg_r <= SIGNED_EN & A[N-1];
              ovf   <= SIGNED_EN && (A == {1'b1, {(N-1){1'b0}}}) && (B == '1);
              state <= DIV;
            end else if (ALU_FUN == OP_DIV) begin
              ALU_OUT   <= '0;
              ERR       <= 1'b1;
              OUT_VALID <= 1'b1;
            end else begin
              ALU_OUT   <= sc_res;
              ERR       <= sc_err;
              OUT_VALID <= 1'b1;
            end
          end
        end
        MUL: begin
          if (cnt == CW'(N)) begin
            ALU_OUT   <= neg_q ? -acc : acc;
            ERR       <= 1'b0;
            OUT_VALID <= 1'b1;
            state     <= IDLE;
          end else begin
            if (work[0]) acc <= acc + opnd;
            opnd <= opnd << 1;
            work <= work >> 1;
            cnt  <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (cnt == CW'(N)) begin
            ALU_OUT   <= {div_r, div_q};
            ERR       <= ovf;
            OUT_VALID <= 1'b1;
            state     <= IDLE;
          end else begin
            if (!rem_diff[N]) begin
              acc  <= {{N{1'b0}}, rem_diff[N-1:0]};
              work <= {work[N-2:0], 1'b1};
            end else begin
              acc  <= {{N{1'b0}}, rem_sh[N-1:0]};
              work <= {work[N-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed-vector self-checking bench for alu_mc
module tb_alu_mc;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [3:0]  ALU_FUN = '0;
  logic        SIGNED_EN = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic        ERR;

  int checks   = 0;
  int failures = 0;

  alu_mc #(.DATA_WIDTH(8), .RESULT_WIDTH(16), .FUN_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .SIGNED_EN(SIGNED_EN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // exp_wait: negedges after the accept edge until OUT_VALID is seen
  // (1 for single-cycle ops, 10 for 8-bit MUL/DIV).
  task automatic run_op(input string tag, input logic [3:0] fun, input logic [7:0] a,
                        input logic [7:0] b, input logic s, input logic [15:0] exp_out,
                        input logic exp_err, input int exp_wait);
    int waited;
    int busy;
    @(negedge CLK);
    A = a; B = b; ALU_FUN = fun; SIGNED_EN = s; IN_VALID = 1'b1;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    waited = 0;
    busy   = 0;
    do begin
      @(negedge CLK);
      waited++;
      if (!IN_READY) busy++;
    end while (!OUT_VALID && waited < 20);
    check({tag, ".wait"}, waited, exp_wait);
    check({tag, ".busy"}, busy, exp_wait - 1);
    check({tag, ".out"}, ALU_OUT, exp_out);
    check({tag, ".err"}, ERR, exp_err);
    @(negedge CLK);
    check({tag, ".strobe"}, OUT_VALID, 1'b0);
    check({tag, ".hold"}, ALU_OUT, exp_out);
  endtask

  initial begin
    int waited;
    int seen;

    #12;
    check("rst.out", ALU_OUT, 16'h0000);
    check("rst.ov", OUT_VALID, 1'b0);
    check("rst.err", ERR, 1'b0);
    check("rst.rdy", IN_READY, 1'b1);
    @(negedge CLK);
    RST = 1'b1;

    run_op("add_u",  4'd0,  8'hFF, 8'h01, 1'b0, 16'h0100, 1'b0, 1);
    run_op("add_s",  4'd0,  8'hFF, 8'hFF, 1'b1, 16'hFFFE, 1'b0, 1);
    run_op("sub_u",  4'd1,  8'h05, 8'h07, 1'b0, 16'hFFFE, 1'b0, 1);
    run_op("sub_s",  4'd1,  8'h80, 8'h01, 1'b1, 16'hFF7F, 1'b0, 1);
    run_op("and",    4'd4,  8'hF0, 8'h3C, 1'b0, 16'h0030, 1'b0, 1);
    run_op("or",     4'd5,  8'hF0, 8'h3C, 1'b1, 16'h00FC, 1'b0, 1);
    run_op("nand",   4'd6,  8'hF0, 8'h3C, 1'b0, 16'h00CF, 1'b0, 1);
    run_op("nor",    4'd7,  8'hF0, 8'h3C, 1'b0, 16'h0003, 1'b0, 1);
    run_op("xor",    4'd8,  8'hF0, 8'h3C, 1'b0, 16'h00CC, 1'b0, 1);
    run_op("xnor",   4'd9,  8'hF0, 8'h3C, 1'b0, 16'h0033, 1'b0, 1);
    run_op("eq_t",   4'd10, 8'h5A, 8'h5A, 1'b0, 16'h0003, 1'b0, 1);
    run_op("eq_f",   4'd10, 8'h5A, 8'h5B, 1'b0, 16'h0000, 1'b0, 1);
    run_op("gt_u",   4'd11, 8'h80, 8'h01, 1'b0, 16'h0001, 1'b0, 1);
    run_op("gt_s",   4'd11, 8'h80, 8'h01, 1'b1, 16'h0002, 1'b0, 1);
    run_op("shr_u",  4'd12, 8'h81, 8'h00, 1'b0, 16'h0040, 1'b0, 1);
    run_op("shr_s",  4'd12, 8'h81, 8'h00, 1'b1, 16'h00C0, 1'b0, 1);
    run_op("shl",    4'd13, 8'h81, 8'h00, 1'b0, 16'h0002, 1'b0, 1);
    run_op("bad_op", 4'd14, 8'h12, 8'h34, 1'b0, 16'h0000, 1'b1, 1);
    run_op("add_ok", 4'd0,  8'h01, 8'h02, 1'b0, 16'h0003, 1'b0, 1);

    run_op("mul_s",   4'd2, 8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0, 10);
    run_op("mul_u",   4'd2, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 10);
    run_op("mul_mn",  4'd2, 8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, 10);
    run_op("mul_neg", 4'd2, 8'h7F, 8'hFF, 1'b1, 16'hFF81, 1'b0, 10);

    run_op("div_u",   4'd3, 8'h64, 8'h07, 1'b0, 16'h020E, 1'b0, 10);
    run_op("div_s",   4'd3, 8'hF9, 8'h02, 1'b1, 16'hFFFD, 1'b0, 10);
    run_op("div_u2",  4'd3, 8'hFF, 8'h10, 1'b0, 16'h0F0F, 1'b0, 10);
    run_op("div_s2",  4'd3, 8'h07, 8'hFE, 1'b1, 16'h01FD, 1'b0, 10);
    run_op("div_z",   4'd3, 8'h55, 8'h00, 1'b0, 16'h0000, 1'b1, 1);
    run_op("div_ovf", 4'd3, 8'h80, 8'hFF, 1'b1, 16'h0080, 1'b1, 10);

    // Reset in the middle of a DIV; prior result 0080 with ERR=1 must clear.
    @(negedge CLK);
    A = 8'h64; B = 8'h07; ALU_FUN = 4'd3; SIGNED_EN = 1'b0; IN_VALID = 1'b1;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("abort.out", ALU_OUT, 16'h0000);
    check("abort.ov", OUT_VALID, 1'b0);
    check("abort.err", ERR, 1'b0);
    check("abort.rdy_in_rst", IN_READY, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge CLK);
      if (OUT_VALID) seen++;
    end
    check("abort.no_ov", seen, 0);
    check("abort.rdy", IN_READY, 1'b1);
    check("abort.out_hold", ALU_OUT, 16'h0000);

    // ADD held on IN_VALID while a MUL is busy, accepted in the MUL's result cycle.
    @(negedge CLK);
    A = 8'h03; B = 8'h04; ALU_FUN = 4'd2; SIGNED_EN = 1'b0; IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    A = 8'h10; B = 8'h20; ALU_FUN = 4'd0;
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (!OUT_VALID && waited < 20);
    check("b2b.mul_wait", waited, 10);
    check("b2b.mul_out", ALU_OUT, 16'h000C);
    check("b2b.rdy", IN_READY, 1'b1);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    @(negedge CLK);
    check("b2b.add_ov", OUT_VALID, 1'b1);
    check("b2b.add_out", ALU_OUT, 16'h0030);
    check("b2b.add_err", ERR, 1'b0);
    @(negedge CLK);
    check("b2b.strobe", OUT_VALID, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
